// File: rtl/gray_rx_pkg.sv
// Shared definitions for the Gray-count receiver: FSM encodings, default
// synchronizer depth and a bit-count helper used for the step-size check.
package gray_rx_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/gray_rx_decoder.sv
// Receives an asynchronous Gray count, synchronizes it, and reports accepted
// single-step changes in binary, flagging multi-bit jumps as a sticky error.
module gray_rx_decoder
    import gray_rx_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gray_in,
    input  logic         clear_err,
    output logic [N-1:0] bin_out,
    output logic         bin_valid,
    output logic         step_dn,
    output logic         wrap,
    output logic         err_multi
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]  sync_r [SYNC_STAGES];
    logic [N-1:0]  g_s;
    logic [N-1:0]  b_s;
    logic [N-1:0]  g_ref_r, g_ref_s;
    logic [N-1:0]  bin_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]   diff_s;
    logic [5:0]    dist_s;
    logic          single_s, multi_s;
    logic          valid_s, dn_s, wrap_s, err_s;
    state_t        state_r, state_s;

    // Synchronizer chain; only the final stage is trusted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign g_s = sync_r[SYNC_STAGES-1];

    gray2bin #(.N(N)) u_gray2bin (
        .gray (g_s),
        .bin  (b_s)
    );

    assign diff_s   = 32'(g_s ^ g_ref_r);
    assign dist_s   = popcount32(diff_s);
    assign single_s = (dist_s == 6'd1);
    assign multi_s  = (dist_s > 6'd1);

    // Next-state and next-output logic for INIT / TRACK / FAULT.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        g_ref_s = g_ref_r;
        bin_s   = bin_out;
        valid_s = 1'b0;
        dn_s    = 1'b0;
        wrap_s  = 1'b0;
        err_s   = err_multi;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == CW'(SYNC_STAGES)) begin
                    g_ref_s = g_s;
                    bin_s   = b_s;
                    state_s = ST_TRACK;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_TRACK, ST_FAULT: begin
                if (single_s) begin
                    g_ref_s = g_s;
                    bin_s   = b_s;
                    valid_s = 1'b1;
                    dn_s    = (b_s == (bin_out - ONE));
                    wrap_s  = (bin_out == '1) && (b_s == '0);
                end else if (multi_s) begin
                    g_ref_s = g_s;
                    bin_s   = b_s;
                    err_s   = 1'b1;
                    state_s = ST_FAULT;
                end else begin
                    g_ref_s = g_ref_r;
                end
                // A simultaneous multi-bit jump keeps the error asserted.
                if ((state_r == ST_FAULT) && clear_err && !multi_s) begin
                    err_s   = 1'b0;
                    state_s = ST_TRACK;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = '0;
            end
        endcase
    end

    // State, reference sample and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_INIT;
            cnt_r     <= '0;
            g_ref_r   <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_dn   <= 1'b0;
            wrap      <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            g_ref_r   <= g_ref_s;
            bin_out   <= bin_s;
            bin_valid <= valid_s;
            step_dn   <= dn_s;
            wrap      <= wrap_s;
            err_multi <= err_s;
        end
    end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (N=4, SYNC_STAGES=2): expectations are
// queued at stimulus time and consumed by a monitor whenever bin_valid fires.
module tb_gray_rx_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray_in;
    logic       clear_err;
    logic [3:0] bin_out;
    logic       bin_valid, step_dn, wrap, err_multi;

    typedef struct {
        int b;
        int dn;
        int w;
        int at;
    } exp_t;

    typedef struct {
        logic [3:0] g;
        int         b;
        int         dn;
        int         w;
    } vec_t;

    exp_t q[$];
    exp_t e;
    vec_t vecs[19];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    gray_rx_decoder #(.N(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_dn   (step_dn),
        .wrap      (wrap),
        .err_multi (err_multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one Gray value, optionally queue its expected pulse, hold 4 cycles.
    task automatic drive(input logic [3:0] g, input bit pulse, input int b, input int dn, input int w);
        @(negedge clk);
        gray_in = g;
        if (pulse) q.push_back('{b, dn, w, cyc + 3});
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin_out"},   int'(bin_out),   0);
        check({tag, "_bin_valid"}, int'(bin_valid), 0);
        check({tag, "_step_dn"},   int'(step_dn),   0);
        check({tag, "_wrap"},      int'(wrap),      0);
        check({tag, "_err_multi"}, int'(err_multi), 0);
    endtask

    // Monitor: every bin_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bin_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got bin_out=%0d required no pulse (cycle %0d)", bin_out, cyc);
                end else begin
                    e = q.pop_front();
                    check("bin_out", int'(bin_out), e.b);
                    check("step_dn", int'(step_dn), e.dn);
                    check("wrap",    int'(wrap),    e.w);
                    check("latency", cyc,           e.at);
                end
            end else begin
                check("idle_pulse", int'(step_dn | wrap), 0);
            end
        end
    end

    initial begin
        vecs = '{
            '{4'b0001,  1, 1, 0}, '{4'b0000,  0, 1, 0}, '{4'b0001,  1, 0, 0},
            '{4'b0011,  2, 0, 0}, '{4'b0010,  3, 0, 0}, '{4'b0110,  4, 0, 0},
            '{4'b0111,  5, 0, 0}, '{4'b0101,  6, 0, 0}, '{4'b0100,  7, 0, 0},
            '{4'b1100,  8, 0, 0}, '{4'b1101,  9, 0, 0}, '{4'b1111, 10, 0, 0},
            '{4'b1110, 11, 0, 0}, '{4'b1010, 12, 0, 0}, '{4'b1011, 13, 0, 0},
            '{4'b1001, 14, 0, 0}, '{4'b1000, 15, 0, 0}, '{4'b0000,  0, 0, 1},
            '{4'b0001,  1, 0, 0}
        };

        rst       = 1'b1;
        gray_in   = 4'b0011;
        clear_err = 1'b0;
        #3;
        check_all_zero("reset");

        // Startup with 0011 held: no pulse, bin_out settles at 2.
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("init_bin_out", int'(bin_out),   2);
        check("init_err",     int'(err_multi), 0);

        // Down-steps, up-count through 15, wrap to 0, then one more step.
        foreach (vecs[i]) drive(vecs[i].g, 1'b1, vecs[i].b, vecs[i].dn, vecs[i].w);

        // Multi-bit jump 0001 -> 0110.
        drive(4'b0110, 1'b0, 0, 0, 0);
        check("jump_err",     int'(err_multi), 1);
        check("jump_bin_out", int'(bin_out),   4);

        // clear_err coincident with another multi-bit jump: error wins.
        @(negedge clk);
        gray_in = 4'b0101;
        @(negedge clk);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        check("clear_vs_jump_err", int'(err_multi), 1);
        check("clear_vs_jump_bin", int'(bin_out),   6);

        // Single step while in FAULT still pulses and keeps the error.
        drive(4'b0100, 1'b1, 7, 0, 0);
        check("fault_step_err", int'(err_multi), 1);

        // Quiet clear returns to TRACK.
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("quiet_clear_err",   int'(err_multi),     0);
        check("quiet_clear_state", int'(dut.state_r),   1);

        drive(4'b1100, 1'b1, 8, 0, 0);

        // Fault again, then asynchronous reset mid-cycle.
        drive(4'b0000, 1'b0, 0, 0, 0);
        check("fault2_err", int'(err_multi), 1);
        #2;
        rst     = 1'b1;
        gray_in = 4'b0111;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reinit_bin_out", int'(bin_out),   5);
        check("reinit_err",     int'(err_multi), 0);

        drive(4'b0101, 1'b1, 6, 0, 0);
        repeat (4) @(negedge clk);
        check("pending_expectations", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 SHALL have parameter N, default 4, Gray word width (N >= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>= 2).
REQ-003 SHALL have port clk  input  1  rising-edge clock of the consuming domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port gray_in  input  N  Gray count from an upstream N-bit Gray counter, asynchronous to clk.
REQ-006 SHALL have port clear_err  input  1  synchronous clear of err_multi.
REQ-007 SHALL have port bin_out  output  N  registered binary equivalent of the last accepted sample.
REQ-008 SHALL have port bin_valid  output  1  one-cycle pulse on each accepted single-step change.
REQ-009 SHALL have port step_dn  output  1  one-cycle pulse when the accepted change is a decrement.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on the 2^N-1 -> 0 transition.
REQ-011 SHALL have port err_multi  output  1  sticky flag: two consecutive synchronized samples differ in more than one bit.

Function
REQ-012 SHALL pass gray_in through a SYNC_STAGES-deep flop chain; only the last stage (g_s) is used downstream.
REQ-013 SHALL convert g_s to binary: b[N-1] = g[N-1]; b[i] = b[i+1] XOR g[i].
REQ-014 SHALL keep a registered reference sample g_ref and implement FSM states INIT, TRACK, FAULT.
REQ-015 INIT: SHALL count SYNC_STAGES cycles after reset release, then load g_ref = g_s, load bin_out, and go to TRACK without pulsing bin_valid.
REQ-016 TRACK, g_s == g_ref: no outputs pulse, state held.
REQ-017 TRACK, Hamming(g_s, g_ref) == 1: SHALL update g_ref and bin_out and pulse bin_valid the next cycle.
REQ-018 Alongside REQ-017: step_dn SHALL pulse if new binary == old binary - 1 (mod 2^N); wrap SHALL pulse if old == 2^N-1 and new == 0.
REQ-019 TRACK, Hamming > 1: SHALL set err_multi, update g_ref and bin_out, not pulse bin_valid, step_dn or wrap, and go to FAULT.
REQ-020 FAULT: SHALL track exactly as TRACK (single steps pulse bin_valid); err_multi stays 1.
REQ-021 FAULT with clear_err=1 SHALL clear err_multi and go to TRACK.
REQ-022 A multi-bit change in the same cycle as clear_err SHALL leave err_multi = 1 and the state FAULT (error wins).
REQ-023 clear_err SHALL have no effect in INIT or TRACK.
REQ-024 Latency: a gray_in change settled before edge k SHALL appear on bin_out / bin_valid after edge k+SYNC_STAGES.
REQ-025 All outputs SHALL be registered; no combinational path from gray_in or clear_err to any output.

Reset
REQ-026 rst=1 SHALL immediately force sync chain = 0, g_ref = 0, bin_out = 0, bin_valid = 0, step_dn = 0, wrap = 0, err_multi = 0, state = INIT, INIT counter = 0.
REQ-027 rst asserted mid-operation SHALL discard all history; after release the block re-runs INIT and raises no error for the first sample.

Structure
REQ-028 A shared package gray_rx_pkg SHALL hold the FSM state encodings (INIT=2'd0, TRACK=2'd1, FAULT=2'd2) and default SYNC_STAGES.
REQ-029 Gray-to-binary conversion SHALL be a separate combinational sub-module gray2bin (parameter N), instantiated once on g_s.
REQ-030 Hamming-distance check SHALL be implemented as a popcount of (g_s XOR g_ref) compared against 1.

Verification (N=4, SYNC_STAGES=2)
REQ-031 Reset release with gray_in=0011 held -> after INIT, bin_out=2, bin_valid never pulses, err_multi=0.
REQ-032 Drive Gray sequence 0000,0001,0011,0010 one value per 4 cycles -> bin_out 0,1,2,3; one bin_valid pulse per change, each 2 edges after the change.
REQ-033 Step gray_in 1000 -> 0000 -> bin_out 15 -> 0; wrap and bin_valid pulse together for one cycle; step_dn=0.
REQ-034 Step gray_in 0011 -> 0001 -> bin_out 2 -> 1; bin_valid and step_dn pulse.
REQ-035 Jump gray_in 0001 -> 0110 -> err_multi=1, bin_out=4, no bin_valid; then pulse clear_err with a simultaneous 0110 -> 0101 jump -> err_multi stays 1; clear_err on a quiet cycle -> err_multi=0, state TRACK.
REQ-036 Assert rst during FAULT -> all outputs 0 immediately; after release no error for the first sample.
